gpi_filter_bank: RTL

- Multi-channel synchronous input conditioner placed behind a bank of pull-up GPI pad cells.
- Per channel, it synchronises the pad receiver output DI into the core clock domain and applies a programmable debounce/glitch filter.
- It generates rise/fall event pulses and sticky interrupt-pending bits.
- It replaces direct use of the raw pad DI in core logic.

---
 rtl/gpi_filter_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/gpi_filter_bank.sv
// Multi-channel GPI conditioner: per-channel synchroniser, debounce filter,
// rise/fall event pulses and sticky interrupt-pending bits.
module gpi_filter_bank #(
  parameter int         NCH         = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         CNT_W       = 8,
  parameter logic       RESET_VAL   = 1'b1
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic [NCH-1:0]   PAD_DI_I,
  input  logic [NCH-1:0]   IE_I,
  input  logic             FILT_EN_I,
  input  logic [CNT_W-1:0] DB_LEN_I,
  input  logic [1:0]       IRQ_MODE_I,
  input  logic [NCH-1:0]   IRQ_CLR_I,
  output logic [NCH-1:0]   DI_O,
  output logic [NCH-1:0]   RISE_O,
  output logic [NCH-1:0]   FALL_O,
  output logic [NCH-1:0]   IRQ_PEND_O,
  output logic             IRQ_O
);

  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] di_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;
  logic [NCH-1:0] pend_reg;
  logic [NCH-1:0] pend_next;
  logic           irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   di_reg;
      logic                   rise_reg;
      logic                   fall_reg;

      // The synchroniser runs regardless of IE_I so a re-enabled channel sees a settled level.
      always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
          sync_reg <= {SYNC_STAGES{RESET_VAL}};
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], PAD_DI_I[gi]};
        end
      end

      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];

      // cnt only increments while below DB_LEN_I, so it saturates instead of wrapping.
      always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
          di_reg   <= RESET_VAL;
          cnt_reg  <= '0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (!IE_I[gi]) begin
            cnt_reg <= '0;
          end else if (sync_out[gi] == di_reg) begin
            cnt_reg <= '0;
          end else if (!FILT_EN_I || (cnt_reg >= DB_LEN_I)) begin
            di_reg   <= sync_out[gi];
            cnt_reg  <= '0;
            rise_reg <= sync_out[gi];
            fall_reg <= ~sync_out[gi];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign di_vec[gi]   = di_reg;
      assign rise_vec[gi] = rise_reg;
      assign fall_vec[gi] = fall_reg;
    end
  endgenerate

  // A new event outranks a clear arriving in the same cycle.
  always_comb begin
    pend_next = (rise_vec & {NCH{IRQ_MODE_I[0]}})
              | (fall_vec & {NCH{IRQ_MODE_I[1]}})
              | (pend_reg & ~IRQ_CLR_I);
  end

  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      pend_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      irq_reg  <= |pend_next;
    end
  end

  assign DI_O       = di_vec;
  assign RISE_O     = rise_vec;
  assign FALL_O     = fall_vec;
  assign IRQ_PEND_O = pend_reg;
  assign IRQ_O      = irq_reg;

endmodule
